// File: rtl/stage_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : stage_seq_if
// Brief    : Handshake bundle between stage_sequencer and its environment.
// Revision : 1.0  initial release
// ============================================================================
interface stage_seq_if #(
    parameter int CNT_W = 16
);
    logic             Start;
    logic             Halt;
    logic             Mem_Op;
    logic             Mem_Ready;
    logic [1:0]       Instr_Stage;
    logic             Busy;
    logic             Mem_Req;
    logic             Retire;
    logic             Halted;
    logic             Fault;
    logic [CNT_W-1:0] Instr_Count;

    // Sequencer side
    modport master (
        input  Start, Halt, Mem_Op, Mem_Ready,
        output Instr_Stage, Busy, Mem_Req, Retire, Halted, Fault, Instr_Count
    );

    // Control unit / memory side
    modport slave (
        output Start, Halt, Mem_Op, Mem_Ready,
        input  Instr_Stage, Busy, Mem_Req, Retire, Halted, Fault, Instr_Count
    );
endinterface
`default_nettype wire

// File: rtl/stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stage_sequencer
// Brief    : Steps instructions through Fetch/Decode/Execute/[Memory], stalls
//            on memory, halts on request and counts retired instructions.
//            Optional memory-wait timeout: define STAGE_SEQ_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module stage_sequencer #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  wire logic     clk,
    input  wire logic     rst,
    stage_seq_if.master   bus
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_MEM    = 3'd4;
    localparam logic [2:0] c_ST_HALTED = 3'd5;
    localparam logic [2:0] c_ST_FAULT  = 3'd6;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("stage_sequencer: TIMEOUT must be >= 1");
    end

    logic [2:0]       r_state;
    logic             r_mem_op;
    logic             r_retire;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       w_stage;
    logic             w_timeout;

`ifdef STAGE_SEQ_TIMEOUT_EN
    localparam int                 c_WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

    logic [c_WAIT_W-1:0] r_wait;

    // Expires on the TIMEOUT-th consecutive cycle without an acknowledge
    assign w_timeout = (r_wait == c_WAIT_LAST) && !bus.Mem_Ready;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_mem_op <= 1'b0;
            r_retire <= 1'b0;
            r_count  <= '0;
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.Start) r_state <= c_ST_FETCH;
                end
                c_ST_FETCH: begin
                    if (bus.Mem_Ready)  r_state <= c_ST_DECODE;
                    else if (w_timeout) r_state <= c_ST_FAULT;
                end
                c_ST_DECODE: begin
                    r_mem_op <= bus.Mem_Op;
                    r_state  <= c_ST_EXEC;
                end
                c_ST_EXEC: begin
                    // Halt outranks a pending memory stage; the halting instruction retires
                    if (bus.Halt) begin
                        r_state  <= c_ST_HALTED;
                        r_retire <= 1'b1;
                        r_count  <= r_count + 1'b1;
                    end else if (r_mem_op) begin
                        r_state  <= c_ST_MEM;
                    end else begin
                        r_state  <= c_ST_FETCH;
                        r_retire <= 1'b1;
                        r_count  <= r_count + 1'b1;
                    end
                end
                c_ST_MEM: begin
                    if (bus.Mem_Ready) begin
                        r_state  <= c_ST_FETCH;
                        r_retire <= 1'b1;
                        r_count  <= r_count + 1'b1;
                    end else if (w_timeout) begin
                        r_state  <= c_ST_FAULT;
                    end
                end
                c_ST_HALTED: begin
                    if (bus.Start) r_state <= c_ST_FETCH;
                end
                c_ST_FAULT: begin
                    r_state <= c_ST_FAULT;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

`ifdef STAGE_SEQ_TIMEOUT_EN
    // Cleared whenever outside a stalled request, so every FETCH/MEM entry starts at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait <= '0;
        end else if (((r_state == c_ST_FETCH) || (r_state == c_ST_MEM)) && !bus.Mem_Ready) begin
            r_wait <= r_wait + 1'b1;
        end else begin
            r_wait <= '0;
        end
    end

    assign bus.Fault = (r_state == c_ST_FAULT);
`else
    assign bus.Fault = 1'b0;
`endif

    always_comb begin
        w_stage = 2'b00;
        case (r_state)
            c_ST_DECODE: w_stage = 2'b01;
            c_ST_EXEC:   w_stage = 2'b10;
            c_ST_MEM:    w_stage = 2'b11;
            default:     w_stage = 2'b00;
        endcase
    end

    assign bus.Instr_Stage = w_stage;
    assign bus.Busy        = (r_state == c_ST_FETCH) || (r_state == c_ST_DECODE) ||
                             (r_state == c_ST_EXEC)  || (r_state == c_ST_MEM);
    assign bus.Mem_Req     = (r_state == c_ST_FETCH) || (r_state == c_ST_MEM);
    assign bus.Halted      = (r_state == c_ST_HALTED);
    assign bus.Retire      = r_retire;
    assign bus.Instr_Count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_sequencer
// Brief    : Directed plus randomized checks of stage_sequencer against a
//            stage-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_stage_sequencer;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 4;
`ifdef STAGE_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stage_seq_if #(.CNT_W(CNT_W)) bus ();

    stage_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase names and per-phase output table
    typedef enum int {P_IDLE, P_FETCH, P_DECODE, P_EXEC, P_MEM, P_HALTED, P_FAULT} phase_t;
    phase_t           m_ph;
    bit               m_needs_mem;
    bit               m_ret;
    logic [CNT_W-1:0] m_cnt;
    int               m_waits;

    function automatic void model_reset();
        m_ph = P_IDLE; m_needs_mem = 0; m_ret = 0; m_cnt = '0; m_waits = 0;
    endfunction

    function automatic void retire_one();
        m_ret = 1;
        m_cnt = m_cnt + 1'b1;
    endfunction

    function automatic void model_edge();
        m_ret = 0;
        if (rst) begin model_reset(); return; end
        case (m_ph)
            P_IDLE, P_HALTED: if (bus.Start) m_ph = P_FETCH;
            P_FETCH, P_MEM: begin
                if (bus.Mem_Ready) begin
                    if (m_ph == P_MEM) retire_one();
                    m_ph = (m_ph == P_MEM) ? P_FETCH : P_DECODE;
                    m_waits = 0;
                end else begin
                    m_waits++;
                    if (TO_EN && m_waits >= TIMEOUT) m_ph = P_FAULT;
                end
            end
            P_DECODE: begin m_needs_mem = bus.Mem_Op; m_ph = P_EXEC; end
            P_EXEC: begin
                if (bus.Halt)            begin retire_one(); m_ph = P_HALTED; end
                else if (m_needs_mem)    m_ph = P_MEM;
                else                     begin retire_one(); m_ph = P_FETCH; end
            end
            default: ;
        endcase
        if (m_ph != P_FETCH && m_ph != P_MEM) m_waits = 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [1:0] e_stage;
        case (m_ph)
            P_DECODE: e_stage = 2'b01;
            P_EXEC:   e_stage = 2'b10;
            P_MEM:    e_stage = 2'b11;
            default:  e_stage = 2'b00;
        endcase
        chk("stage",   32'(bus.Instr_Stage), 32'(e_stage));
        chk("busy",    32'(bus.Busy),    32'(m_ph inside {P_FETCH, P_DECODE, P_EXEC, P_MEM}));
        chk("mem_req", 32'(bus.Mem_Req), 32'(m_ph inside {P_FETCH, P_MEM}));
        chk("retire",  32'(bus.Retire),  32'(m_ret));
        chk("halted",  32'(bus.Halted),  32'(m_ph == P_HALTED));
        chk("fault",   32'(bus.Fault),   32'(m_ph == P_FAULT));
        chk("count",   32'(bus.Instr_Count), 32'(m_cnt));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input bit s, input bit h, input bit mo, input bit mr);
        bus.Start = s; bus.Halt = h; bus.Mem_Op = mo; bus.Mem_Ready = mr;
    endtask

    initial begin
        drive(0, 0, 0, 0);
        model_reset();
        #2;
        check_all();
        chk("reset_count", 32'(bus.Instr_Count), 32'd0);
        step();
        rst = 1'b0;

        // Back-to-back non-memory instructions
        drive(1, 0, 0, 1);
        step();
        drive(0, 0, 0, 1);
        for (int i = 0; i < 9; i++) step();
        chk("three_retired", 32'(bus.Instr_Count), 32'd3);

        // One memory instruction: F D E M -> F
        drive(0, 0, 1, 1);
        for (int i = 0; i < 4; i++) step();
        chk("mem_instr_retire", 32'(bus.Retire), 32'd1);
        chk("mem_instr_stage", 32'(bus.Instr_Stage), 32'd0);

        // Fetch stall
        drive(0, 0, 0, 0);
        for (int i = 0; i < (TO_EN ? TIMEOUT - 1 : 5); i++) step();
        chk("stall_mem_req", 32'(bus.Mem_Req), 32'd1);
        drive(0, 0, 0, 1);
        step();
        chk("stall_release", 32'(bus.Instr_Stage), 32'd1);

        // Halt beats Mem_Op in Execute
        drive(0, 0, 1, 1);
        step();
        drive(0, 1, 1, 1);
        step();
        chk("halt_halted", 32'(bus.Halted), 32'd1);
        chk("halt_busy", 32'(bus.Busy), 32'd0);
        chk("halt_retire", 32'(bus.Retire), 32'd1);
        drive(1, 0, 0, 1);
        step();
        chk("restart_busy", 32'(bus.Busy), 32'd1);

        // Asynchronous reset during a memory wait
        drive(0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step();
        drive(0, 0, 1, 0);
        step();
        chk("in_mem", 32'(bus.Instr_Stage), 32'd3);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        step();
        rst = 1'b0;

        // Memory-wait timeout
        if (TO_EN) begin
            drive(1, 0, 0, 0);
            step();
            drive(0, 0, 0, 0);
            for (int i = 0; i < TIMEOUT; i++) step();
            chk("timeout_fault", 32'(bus.Fault), 32'd1);
            drive(1, 0, 0, 0);
            step();
            chk("fault_sticky", 32'(bus.Fault), 32'd1);
            rst = 1'b1;
            step();
            rst = 1'b0;
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                  1'($urandom), ($urandom_range(0, 9) < 7));
            rst = ($urandom_range(0, 79) == 0);
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
